control_fsm: RTL

CONTROL_FSM -- requirements
Module: control_fsm

---
 rtl/mips_pkg.sv | 50 +++++
 rtl/control_fsm.sv | 132 +++++++++++++
 2 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path: state encodings,
// opcodes and the select/op codes understood by the datapath and ALU decoder.
package mips_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXEC    = 4'd6,
        RTYPEWB = 4'd7,
        BRANCH  = 4'd8,
        JUMP    = 4'd9,
        ADDIEX  = 4'd10,
        ADDIWB  = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic isSupported(input logic [5:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/control_fsm.sv
// Moore control FSM for the multicycle MIPS datapath; every control output
// except illegal_op is a pure decode of the current state.
module control_fsm #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic [1:0]         PCSource,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);
    import mips_pkg::*;

    state_t currentState;
    state_t nextState;

    // State register and the registered illegal-opcode pulse, both cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            currentState <= FETCH;
            illegal_op   <= 1'b0;
        end else begin
            currentState <= nextState;
            illegal_op   <= (currentState == DECODE) && !isSupported(opcode);
        end
    end

    // Next-state logic; opcode only matters in DECODE and MEMADR
    always_comb begin
        nextState = FETCH;
        case (currentState)
            FETCH:   nextState = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: nextState = MEMADR;
                    OP_RTYPE:     nextState = EXEC;
                    OP_BEQ:       nextState = BRANCH;
                    OP_J:         nextState = JUMP;
                    OP_ADDI:      nextState = ADDIEX;
                    default:      nextState = FETCH;
                endcase
            end
            MEMADR: begin
                if (opcode == OP_LW)      nextState = MEMRD;
                else if (opcode == OP_SW) nextState = MEMWR;
                else                      nextState = FETCH;
            end
            MEMRD:   nextState = MEMWB;
            EXEC:    nextState = RTYPEWB;
            ADDIEX:  nextState = ADDIWB;
            default: nextState = FETCH;
        endcase
    end

    // Output decode; unreachable encodings fall into the all-low default
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REG;
        ALUOp       = ALUOP_ADD;
        PCSource    = PCSRC_ALU;
        case (currentState)
            FETCH: begin
                MemRead  = 1'b1;
                IRWrite  = 1'b1;
                ALUSrcB  = SRCB_FOUR;
                PCWrite  = 1'b1;
            end
            DECODE:  ALUSrcB = SRCB_BRANCH;
            MEMADR, ADDIEX: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = SRCB_IMM;
            end
            MEMRD: begin
                MemRead  = 1'b1;
                IorD     = 1'b1;
            end
            MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            EXEC: begin
                ALUSrcA  = 1'b1;
                ALUOp    = ALUOP_FUNCT;
            end
            RTYPEWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
            end
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
            end
            ADDIWB:  RegWrite = 1'b1;
            default: ;
        endcase
    end

    assign state = STATE_W'(currentState);

endmodule
